// File: rtl/razor_replay_ctrl.sv
// razor_replay_ctrl: capture/check sequencer with Razor replay and flush for one decoder section.
// Every output is registered from the next state, so it follows the state entered at each edge.
module razor_replay_ctrl #(
  parameter int STAGES    = 4,
  parameter int LEN_W     = 8,
  parameter int MAX_RETRY = 3,
  parameter int CLR_CYC   = 2,
  parameter int CNT_W     = 16
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              abort,
  input  logic [STAGES-1:0] Error_current,
  output logic              Enable,
  output logic              nClear,
  output logic              in_advance,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [CNT_W-1:0]  err_total,
  output logic [LEN_W-1:0]  item_idx
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int CW = $clog2(CLR_CYC + 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);
  localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_CYC - 1);

  typedef enum logic [2:0] {IDLE, CAPTURE, CHECK, FLUSH, DONE} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [CW-1:0]    clr_q, clr_d;
  logic [CNT_W-1:0] errcnt_q, errcnt_d;
  logic             fail_q, fail_d;
  logic             adv_d;
  logic             en_q, nclr_q, adv_q, busy_q, done_q;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    retry_d  = retry_q;
    clr_d    = clr_q;
    errcnt_d = errcnt_q;
    fail_d   = fail_q;
    adv_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = (frame_len == '0) ? LEN_W'(1) : frame_len;
          idx_d    = '0;
          errcnt_d = '0;
          fail_d   = 1'b0;
          retry_d  = '0;
          state_d  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (abort) begin
          clr_d   = '0;
          fail_d  = 1'b1;
          state_d = FLUSH;
        end else begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        // Abort overrides both the error replay and normal completion.
        if (abort) begin
          clr_d   = '0;
          fail_d  = 1'b1;
          state_d = FLUSH;
        end else if (|Error_current) begin
          if (errcnt_q != '1) errcnt_d = errcnt_q + 1'b1;
          retry_d = retry_q + 1'b1;
          if (retry_q == RETRY_LAST) begin
            clr_d   = '0;
            fail_d  = 1'b1;
            state_d = FLUSH;
          end else begin
            state_d = CAPTURE;
          end
        end else begin
          retry_d = '0;
          adv_d   = 1'b1;
          if (idx_q == len_q - 1'b1) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = CAPTURE;
          end
        end
      end
      FLUSH: begin
        if (clr_q == CLR_LAST) state_d = DONE;
        else                   clr_d   = clr_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      len_q    <= LEN_W'(1);
      idx_q    <= '0;
      retry_q  <= '0;
      clr_q    <= '0;
      errcnt_q <= '0;
      fail_q   <= 1'b0;
      en_q     <= 1'b0;
      nclr_q   <= 1'b1;
      adv_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      retry_q  <= retry_d;
      clr_q    <= clr_d;
      errcnt_q <= errcnt_d;
      fail_q   <= fail_d;
      en_q     <= (state_d == CAPTURE);
      nclr_q   <= (state_d != FLUSH);
      adv_q    <= adv_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
    end
  end

  assign Enable     = en_q;
  assign nClear     = nclr_q;
  assign in_advance = adv_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign err_total  = errcnt_q;
  assign item_idx   = idx_q;

endmodule
